// File: rtl/kfpga_config_pkg.sv
// Shared types and constants for the kFPGA configuration loader.
// Optional CRC check is compiled in with KFPGA_CONFIG_CRC_EN.
package kfpga_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
`ifdef KFPGA_CONFIG_CRC_EN
        , ST_CHECK = 3'd5
`endif
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Number of host words needed to carry the 16-bit expected CRC.
    function automatic int crc_word_count(input int word_width);
        return (16 + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/kfpga_config_loader_if.sv
// Word-wide bitstream stream from the host bridge into the loader.
interface kfpga_config_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/kfpga_config_crc16.sv
// Serial-input CRC-16-CCITT (poly 0x1021, init 0xFFFF), one bit per enabled cycle.
module kfpga_config_crc16
    import kfpga_config_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_reg;
    logic        feedback;

    assign feedback = crc_reg[15] ^ bit_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_reg <= CRC_INIT;
        end else if (clear) begin
            crc_reg <= CRC_INIT;
        end else if (bit_valid) begin
            crc_reg <= {crc_reg[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end

    assign crc = crc_reg;
endmodule

// File: rtl/kfpga_config_loader.sv
// Streams a host bitstream MSB-first into the kFPGA serial config chain and
// sequences the core reset/enable release. CRC check enabled by KFPGA_CONFIG_CRC_EN.
module kfpga_config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CHAIN_LENGTH = 1024,
    parameter int WORD_WIDTH   = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    kfpga_config_loader_if.slave              s,
    output logic                              cfg_bit,
    output logic                              cfg_enable,
    output logic                              cfg_nreset,
    output logic                              core_nreset,
    output logic                              core_enable,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [$clog2(CHAIN_LENGTH+1)-1:0] bit_count
`ifdef KFPGA_CONFIG_CRC_EN
    ,
    output logic [15:0]                       crc_value
`endif
);
    localparam int CW  = $clog2(CHAIN_LENGTH + 1);
    localparam int BW  = $clog2(WORD_WIDTH + 1);
    localparam int CLW = $clog2(CLEAR_CYCLES + 1);

    state_t                  state_reg, state_next;
    logic [CLW-1:0]          clear_cnt_reg, clear_cnt_next;
    logic [WORD_WIDTH-1:0]   shreg_reg, shreg_next;
    logic [BW-1:0]           bits_left_reg, bits_left_next;
    logic [CW-1:0]           load_left_reg, load_left_next;
    logic [CW-1:0]           bit_count_reg, bit_count_next;
    logic cfg_bit_reg, cfg_bit_next, cfg_enable_reg, cfg_enable_next;
    logic cfg_nreset_reg, cfg_nreset_next, core_nreset_reg, core_nreset_next;
    logic core_enable_reg, core_enable_next, ready_reg, ready_next;
    logic busy_reg, busy_next, done_reg, done_next, error_reg, error_next;
    logic accept, start_ok;
    int   take;

`ifdef KFPGA_CONFIG_CRC_EN
    localparam int CRC_WORDS = crc_word_count(WORD_WIDTH);
    localparam int CRC_BITS  = CRC_WORDS * WORD_WIDTH;
    localparam int CKW       = $clog2(CRC_WORDS + 1);

    logic [CKW-1:0]                 crc_left_reg, crc_left_next;
    logic [CRC_BITS-1:0]            crc_exp_reg, crc_exp_next;
    logic [CRC_BITS+WORD_WIDTH-1:0] crc_cat;
    logic [15:0]                    crc_run;

    kfpga_config_crc16 u_crc (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .bit_valid ((state_reg == ST_LOAD) && (bits_left_reg != '0)),
        .bit_in    (shreg_reg[WORD_WIDTH-1]),
        .crc       (crc_run)
    );
    assign crc_value = crc_run;
`endif

    assign accept   = s.valid && ready_reg;
    assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                (state_reg == ST_ERROR));

    always_comb begin
        state_next       = state_reg;
        clear_cnt_next   = clear_cnt_reg;
        shreg_next       = shreg_reg;
        bits_left_next   = bits_left_reg;
        load_left_next   = load_left_reg;
        bit_count_next   = bit_count_reg;
        cfg_bit_next     = cfg_bit_reg;
        cfg_enable_next  = 1'b0;
        cfg_nreset_next  = 1'b1;
        core_nreset_next = 1'b0;
        core_enable_next = 1'b0;
        take             = 0;
`ifdef KFPGA_CONFIG_CRC_EN
        crc_left_next    = crc_left_reg;
        crc_exp_next     = crc_exp_reg;
        crc_cat          = {crc_exp_reg, s.data};
`endif
        case (state_reg)
            ST_CLEAR: begin
                cfg_nreset_next = 1'b0;
                if (clear_cnt_reg == '0) begin
                    state_next      = ST_LOAD;
                    cfg_nreset_next = 1'b1;
                end else begin
                    clear_cnt_next = clear_cnt_reg - 1'b1;
                end
            end
            ST_LOAD: begin
                if (bits_left_reg != '0) begin
                    cfg_bit_next    = shreg_reg[WORD_WIDTH-1];
                    cfg_enable_next = 1'b1;
                    shreg_next      = shreg_reg << 1;
                    bits_left_next  = bits_left_reg - 1'b1;
                    bit_count_next  = bit_count_reg + 1'b1;
                    if ((bits_left_reg == 1) && (load_left_reg == '0)) begin
`ifdef KFPGA_CONFIG_CRC_EN
                        state_next    = ST_CHECK;
                        crc_left_next = CKW'(CRC_WORDS);
`else
                        state_next       = ST_DONE;
                        core_nreset_next = 1'b1;
`endif
                    end
                end
                // Final word is capped to the bits still owed; its spare LSBs never shift.
                if (accept) begin
                    take           = (int'(load_left_reg) > WORD_WIDTH) ? WORD_WIDTH
                                                                        : int'(load_left_reg);
                    shreg_next     = s.data;
                    bits_left_next = BW'(take);
                    load_left_next = load_left_reg - CW'(take);
                end
            end
`ifdef KFPGA_CONFIG_CRC_EN
            ST_CHECK: begin
                if (accept) begin
                    crc_exp_next  = crc_cat[CRC_BITS-1:0];
                    crc_left_next = crc_left_reg - 1'b1;
                    // Expected CRC is the first 16 bits received, MSB-first.
                    if (crc_left_reg == 1) begin
                        if (crc_cat[CRC_BITS-1 -: 16] == crc_run) begin
                            state_next       = ST_DONE;
                            core_nreset_next = 1'b1;
                        end else begin
                            state_next = ST_ERROR;
                        end
                    end
                end
            end
`endif
            ST_DONE: begin
                core_nreset_next = 1'b1;
                core_enable_next = core_nreset_reg;
            end
            default: ;
        endcase

        if (start_ok) begin
            state_next       = ST_CLEAR;
            clear_cnt_next   = CLW'(CLEAR_CYCLES - 1);
            bit_count_next   = '0;
            bits_left_next   = '0;
            load_left_next   = CW'(CHAIN_LENGTH);
            cfg_nreset_next  = 1'b0;
            core_nreset_next = 1'b0;
            core_enable_next = 1'b0;
        end
        if (abort) begin
            state_next       = ST_IDLE;
            bits_left_next   = '0;
            load_left_next   = '0;
            cfg_enable_next  = 1'b0;
            cfg_nreset_next  = 1'b1;
            core_nreset_next = 1'b0;
            core_enable_next = 1'b0;
        end

        ready_next = (state_next == ST_LOAD) && (bits_left_next <= 1) && (load_left_next != '0);
        busy_next  = (state_next == ST_CLEAR) || (state_next == ST_LOAD);
`ifdef KFPGA_CONFIG_CRC_EN
        ready_next = ready_next || ((state_next == ST_CHECK) && (crc_left_next != '0));
        busy_next  = busy_next || (state_next == ST_CHECK);
`endif
        done_next  = (state_next == ST_DONE);
        error_next = (state_next == ST_ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            clear_cnt_reg   <= '0;
            shreg_reg       <= '0;
            bits_left_reg   <= '0;
            load_left_reg   <= '0;
            bit_count_reg   <= '0;
            cfg_bit_reg     <= 1'b0;
            cfg_enable_reg  <= 1'b0;
            cfg_nreset_reg  <= 1'b1;
            core_nreset_reg <= 1'b0;
            core_enable_reg <= 1'b0;
            ready_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
`ifdef KFPGA_CONFIG_CRC_EN
            crc_left_reg    <= '0;
            crc_exp_reg     <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            clear_cnt_reg   <= clear_cnt_next;
            shreg_reg       <= shreg_next;
            bits_left_reg   <= bits_left_next;
            load_left_reg   <= load_left_next;
            bit_count_reg   <= bit_count_next;
            cfg_bit_reg     <= cfg_bit_next;
            cfg_enable_reg  <= cfg_enable_next;
            cfg_nreset_reg  <= cfg_nreset_next;
            core_nreset_reg <= core_nreset_next;
            core_enable_reg <= core_enable_next;
            ready_reg       <= ready_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
`ifdef KFPGA_CONFIG_CRC_EN
            crc_left_reg    <= crc_left_next;
            crc_exp_reg     <= crc_exp_next;
`endif
        end
    end

    assign s.ready     = ready_reg;
    assign cfg_bit     = cfg_bit_reg;
    assign cfg_enable  = cfg_enable_reg;
    assign cfg_nreset  = cfg_nreset_reg;
    assign core_nreset = core_nreset_reg;
    assign core_enable = core_enable_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;
    assign bit_count   = bit_count_reg;
endmodule
